// File: rtl/ocra1_frame_packer.sv
// Buffers X/Y/Z/Z2 gradient frames, paces their release and serialises each into a 4-word ocra1_iface burst.
// Optional build macro OCRA1_PACKER_OFFBIN_EN: packs codes as offset binary instead of two's complement.
module ocra1_frame_packer #(
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [71:0]              frame_i,
  input  logic                     frame_valid_i,
  output logic                     frame_ready_o,
  input  logic                     init_i,
  input  logic [15:0]              interval_i,
  input  logic                     iface_busy_i,
  output logic [31:0]              data_o,
  output logic                     valid_o,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level_o,
  output logic                     underrun_o
);

  localparam int DATA_W = 18;
  localparam int LVL_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam logic [LVL_W-1:0] DEPTH_LVL    = LVL_W'(DEPTH);
  localparam logic [23:0]      INIT_PAYLOAD = 24'h200002;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_INIT = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] code_map(input logic signed [DATA_W-1:0] code);
`ifdef OCRA1_PACKER_OFFBIN_EN
    code_map = {~code[DATA_W-1], code[DATA_W-2:0]};
`else
    code_map = code;
`endif
  endfunction

  function automatic logic [23:0] frame_payload(input logic signed [DATA_W-1:0] code);
    frame_payload = {4'h1, code_map(code), 2'b00};
  endfunction

  state_t                     state, state_nxt;
  logic [1:0]                 ch_cnt, ch_cnt_nxt;
  logic [71:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]           level, level_nxt;
  logic                       wr_en, rd_en, fifo_empty;
  logic [71:0]                head;
  logic [15:0]                ivl_cnt;
  logic                       init_pending, ur_armed, ur_fire;
  logic                       start_init, start_send;
  logic signed [DATA_W-1:0]   frame_code;
  logic [23:0]                payload_nxt;
  logic                       valid_nxt;
  logic [31:0]                data_nxt;

  // Frame FIFO: a full FIFO refuses writes even when a pop happens in the same cycle
  assign wr_en      = frame_valid_i && frame_ready_o;
  assign rd_en      = (state == ST_SEND) && (ch_cnt == 2'd3);
  assign fifo_empty = (level == '0);
  assign head       = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({wr_en, rd_en})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= frame_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      frame_ready_o <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level         <= level_nxt;
      frame_ready_o <= (level_nxt != DEPTH_LVL);
    end
  end

  assign fifo_level_o = level;

  // Burst sequencing: busy is only looked at in IDLE, so a started burst always runs to ch 3
  assign start_init = (state == ST_IDLE) && init_pending && !iface_busy_i;
  assign start_send = (state == ST_IDLE) && !fifo_empty && (ivl_cnt == '0) &&
                      !iface_busy_i && !init_pending;

  always_comb begin
    state_nxt  = state;
    ch_cnt_nxt = ch_cnt;
    case (state)
      ST_IDLE: begin
        if (start_init) begin
          state_nxt  = ST_INIT;
          ch_cnt_nxt = '0;
        end else if (start_send) begin
          state_nxt  = ST_SEND;
          ch_cnt_nxt = '0;
        end
      end
      ST_SEND, ST_INIT: begin
        if (ch_cnt == 2'd3) begin
          state_nxt  = ST_IDLE;
          ch_cnt_nxt = '0;
        end else begin
          ch_cnt_nxt = ch_cnt + 2'd1;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        ch_cnt_nxt = '0;
      end
    endcase
  end

  // Output word is built from the next state so data_o/valid_o come straight from flops
  always_comb begin
    frame_code = '0;
    case (ch_cnt_nxt)
      2'd0:    frame_code = head[17:0];
      2'd1:    frame_code = head[35:18];
      2'd2:    frame_code = head[53:36];
      default: frame_code = head[71:54];
    endcase
    payload_nxt = INIT_PAYLOAD;
    if (state_nxt == ST_SEND) payload_nxt = frame_payload(frame_code);
    valid_nxt = (state_nxt != ST_IDLE);
    data_nxt  = valid_nxt ? {5'd0, ch_cnt_nxt, (ch_cnt_nxt == 2'd3), payload_nxt} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ch_cnt  <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      state   <= state_nxt;
      ch_cnt  <= ch_cnt_nxt;
      valid_o <= valid_nxt;
      data_o  <= data_nxt;
    end
  end

  // Interval counter is loaded one cycle ahead of the first word with interval-1, so it
  // reaches zero in the decision cycle that puts the next first word exactly interval_i later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ivl_cnt <= '0;
    end else if (start_send) begin
      ivl_cnt <= (interval_i == '0) ? '0 : interval_i - 16'd1;
    end else if (ivl_cnt != '0) begin
      ivl_cnt <= ivl_cnt - 16'd1;
    end
  end

  // A new init request in the same cycle as the burst start wins and queues another burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_pending <= 1'b0;
    end else if (init_i) begin
      init_pending <= 1'b1;
    end else if (start_init) begin
      init_pending <= 1'b0;
    end
  end

  // Underrun fires once per completed frame burst, then waits for the next one to re-arm
  assign ur_fire = ur_armed && (ivl_cnt == '0) && fifo_empty && (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ur_armed   <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= ur_fire;
      if (rd_en) begin
        ur_armed <= 1'b1;
      end else if (ur_fire) begin
        ur_armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ocra1_frame_packer.sv
// Scoreboard bench for ocra1_frame_packer: expected burst words are queued as stimulus is driven.
`timescale 1ns/1ps
module tb_ocra1_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] frame_i;
  logic        frame_valid_i;
  logic        frame_ready_o;
  logic        init_i;
  logic [15:0] interval_i;
  logic        iface_busy_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic [3:0]  fifo_level_o;
  logic        underrun_o;

  ocra1_frame_packer #(.FIFO_DEPTH_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .frame_i(frame_i), .frame_valid_i(frame_valid_i),
    .frame_ready_o(frame_ready_o), .init_i(init_i), .interval_i(interval_i),
    .iface_busy_i(iface_busy_i), .data_o(data_o), .valid_o(valid_o),
    .fifo_level_o(fifo_level_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  int          start_q[$];
  int          last_q[$];
  int          ur_cyc_q[$];
  int          ur_lvl_q[$];
  logic        busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] pay(input logic [17:0] c);
`ifdef OCRA1_PACKER_OFFBIN_EN
    return {4'h1, c ^ 18'h20000, 2'b00};
`else
    return {4'h1, c, 2'b00};
`endif
  endfunction

  function automatic logic [31:0] mk_word(input int ch, input logic [23:0] p);
    logic [1:0] c2;
    c2 = 2'(ch);
    return {5'd0, c2, (ch == 3), p};
  endfunction

  task automatic push_frame(input logic [71:0] f);
    for (int ch = 0; ch < 4; ch++) exp_q.push_back(mk_word(ch, pay(f[18*ch +: 18])));
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_frame(input logic [71:0] f, output bit acc, output int stim);
    frame_i       = f;
    frame_valid_i = 1'b1;
    acc           = frame_ready_o;
    stim          = cyc;
    tick(1);
    frame_valid_i = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int lim);
    int k;
    k = 0;
    while (start_q.size() < n && k < lim) begin tick(1); k++; end
    chk("start_timeout", (start_q.size() >= n), 1'b1);
  endtask

  task automatic wait_drain(input int lim);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || valid_o) && k < lim) begin tick(1); k++; end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: every valid word is popped against the scoreboard; burst starts and underruns are logged
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (data_o[26:25] == 2'd0) begin
        start_q.push_back(cyc);
        chk("start_while_busy", busy_prev, 1'b0);
      end
      if (data_o[24]) last_q.push_back(cyc);
      if (exp_q.size() == 0) chk("spurious_valid", valid_o, 1'b0);
      else chk("word", data_o, exp_q.pop_front());
    end
    if (underrun_o) begin
      ur_cyc_q.push_back(cyc);
      ur_lvl_q.push_back(int'(fifo_level_o));
    end
    busy_prev = iface_busy_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] f;
    logic [71:0] tp_frame;
    logic [31:0] tp_words [4];
    bit          acc;
    int          stim;
    int          k;

    tp_frame = {18'h3FFFF, 18'd3, 18'd2, 18'd1};
`ifdef OCRA1_PACKER_OFFBIN_EN
    tp_words = '{32'h00180004, 32'h02180008, 32'h0418000C, 32'h0717FFFC};
`else
    tp_words = '{32'h00100004, 32'h02100008, 32'h0410000C, 32'h071FFFFC};
`endif

    rst_n = 1'b0; frame_i = '0; frame_valid_i = 1'b0; init_i = 1'b0;
    interval_i = '0; iface_busy_i = 1'b0;
    tick(3);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_level", fifo_level_o, 0);
    chk("rst_ready", frame_ready_o, 1);
    rst_n = 1'b1;
    tick(3);

    // DAC init burst
    start_q.delete(); last_q.delete();
    exp_q.push_back(32'h00200002); exp_q.push_back(32'h02200002);
    exp_q.push_back(32'h04200002); exp_q.push_back(32'h07200002);
    init_i = 1'b1; stim = cyc; tick(1); init_i = 1'b0;
    wait_starts(1, 20);
    chk("init_latency", (start_q.size() > 0) ? start_q[0] : -1, stim + 2);
    wait_drain(20);
    chk("init_last", (last_q.size() > 0) ? last_q[0] : -1, stim + 5);

    // Reference frame
    start_q.delete(); last_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(tp_words[i]);
    write_frame(tp_frame, acc, stim);
    wait_starts(1, 20);
    chk("frame_latency", (start_q.size() > 0) ? start_q[0] : -1, stim + 2);
    wait_drain(20);
    chk("frame_last", (last_q.size() > 0) ? last_q[0] : -1, stim + 5);

    // Random frames
    for (int i = 0; i < 3; i++) begin
      start_q.delete();
      f = {8'($urandom()), $urandom(), $urandom()};
      push_frame(f);
      write_frame(f, acc, stim);
      wait_starts(1, 20);
      chk("rand_latency", (start_q.size() > 0) ? start_q[0] : -1, stim + 2);
      wait_drain(20);
    end
    tick(10);

    // Interval pacing and underrun
    interval_i = 16'd100; iface_busy_i = 1'b1;
    start_q.delete(); ur_cyc_q.delete(); ur_lvl_q.delete();
    for (int i = 0; i < 2; i++) begin
      f = {8'($urandom()), $urandom(), $urandom()};
      push_frame(f);
      write_frame(f, acc, stim);
    end
    chk("preload_level", fifo_level_o, 2);
    iface_busy_i = 1'b0;
    wait_starts(2, 300);
    chk("interval_gap", (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, 100);
    tick(130);
    chk("underrun_count", ur_cyc_q.size(), 1);
    chk("underrun_time", (ur_cyc_q.size() > 0) ? ur_cyc_q[0] : -1,
        (start_q.size() > 1) ? start_q[1] + 100 : -2);
    chk("underrun_level", (ur_lvl_q.size() > 0) ? ur_lvl_q[0] : -1, 0);

    // Fill while busy, overflow attempt, drain under random busy
    interval_i = '0; iface_busy_i = 1'b1; start_q.delete();
    for (int i = 0; i < 9; i++) begin
      f = {8'($urandom()), $urandom(), $urandom()};
      if (i < 8) push_frame(f);
      write_frame(f, acc, stim);
      chk("accept", acc, (i < 8));
      chk("ready_after_wr", frame_ready_o, (i < 7));
    end
    chk("level_full", fifo_level_o, 8);
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      iface_busy_i = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    iface_busy_i = 1'b0;
    wait_drain(100);
    chk("full_bursts", start_q.size(), 8);
    tick(10);

    // Reset during the ch-1 word
    for (int i = 0; i < 2; i++) begin
      f = {8'($urandom()), $urandom(), $urandom()};
      push_frame(f);
      write_frame(f, acc, stim);
    end
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (valid_o && data_o[26:25] == 2'd1) break;
      k++;
    end
    chk("ch1_seen", (k < 20), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_level", fifo_level_o, 0);
    exp_q.delete(); start_q.delete();
    @(posedge clk); #1;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    chk("post_rst_quiet", start_q.size(), 0);
    f = {8'($urandom()), $urandom(), $urandom()};
    push_frame(f);
    write_frame(f, acc, stim);
    wait_starts(1, 20);
    chk("post_rst_latency", (start_q.size() > 0) ? start_q[0] : -1, stim + 2);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
